// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard FIFO sequencer: clears the receiver after reset, pops one byte per
// three-cycle handshake and turns E0/F0-prefixed scan codes into press/repeat/release events.
module ps2_kbd_ctrl #(
   parameter int CLR_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] kbd_data,
   input  logic       kbd_ready,
   input  logic       kbd_overflow,
   output logic       kbd_nextdata_n,
   output logic       kbd_clrn,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_valid,
   output logic       key_release,
   output logic       key_repeat,
   output logic       key_held,
   output logic [7:0] press_count,
   output logic       ovf_sticky,
   input  logic       ovf_clr
);

   localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      POP  = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] clr_cnt;
   logic [7:0]    code_q;
   logic          ext_pend;
   logic          brk_pend;
   logic [7:0]    held_code;
   logic          held_ext;
   logic          held_match;

   assign held_match = key_held && (code_q == held_code) && (ext_pend == held_ext);

   // Handshake sequencer with byte decode; every output is registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= INIT;
         clr_cnt        <= '0;
         kbd_clrn       <= 1'b0;
         kbd_nextdata_n <= 1'b1;
         code_q         <= 8'h00;
         ext_pend       <= 1'b0;
         brk_pend       <= 1'b0;
         held_code      <= 8'h00;
         held_ext       <= 1'b0;
         key_code       <= 8'h00;
         key_ext        <= 1'b0;
         key_valid      <= 1'b0;
         key_release    <= 1'b0;
         key_repeat     <= 1'b0;
         key_held       <= 1'b0;
         press_count    <= 8'h00;
      end else begin
         kbd_nextdata_n <= 1'b1;
         key_valid      <= 1'b0;
         case (state)
            INIT: begin
               if (clr_cnt == CLR_LAST) begin
                  state    <= IDLE;
                  kbd_clrn <= 1'b1;
               end else begin
                  clr_cnt  <= clr_cnt + CW'(1);
               end
            end
            IDLE: begin
               if (kbd_ready) begin
                  code_q         <= kbd_data;
                  kbd_nextdata_n <= 1'b0;
                  state          <= POP;
               end else begin
                  state          <= IDLE;
               end
            end
            POP: begin
               state <= GAP;
               if (code_q == 8'hE0) begin
                  ext_pend <= 1'b1;
               end else if (code_q == 8'hF0) begin
                  brk_pend <= 1'b1;
               end else begin
                  key_valid <= 1'b1;
                  key_code  <= code_q;
                  key_ext   <= ext_pend;
                  ext_pend  <= 1'b0;
                  brk_pend  <= 1'b0;
                  if (brk_pend) begin
                     key_release <= 1'b1;
                     key_repeat  <= 1'b0;
                     if (held_match) begin
                        key_held <= 1'b0;
                     end
                  end else if (held_match) begin
                     key_release <= 1'b0;
                     key_repeat  <= 1'b1;
                  end else begin
                     // A new key takes over as the held key even if another was down.
                     key_release <= 1'b0;
                     key_repeat  <= 1'b0;
                     key_held    <= 1'b1;
                     held_code   <= code_q;
                     held_ext    <= ext_pend;
                     press_count <= press_count + 8'd1;
                  end
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state    <= INIT;
               clr_cnt  <= '0;
               kbd_clrn <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overflow: a new overflow outranks a clear in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_sticky <= 1'b0;
      end else if (kbd_overflow) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end else begin
         ovf_sticky <= ovf_sticky;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: a queue-based receiver FIFO plus a scan-code event model,
// compared against the DUT on every falling edge.
module tb_ps2_kbd_ctrl;
   localparam int CLR = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] kbd_data = 8'h00;
   logic       kbd_ready = 1'b0;
   logic       kbd_overflow = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       kbd_nextdata_n, kbd_clrn, key_ext, key_valid, key_release, key_repeat;
   logic       key_held, ovf_sticky;
   logic [7:0] key_code, press_count;

   ps2_kbd_ctrl #(.CLR_CYCLES(CLR)) dut (
      .clock(clock), .reset(reset), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
      .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n), .kbd_clrn(kbd_clrn),
      .key_code(key_code), .key_ext(key_ext), .key_valid(key_valid),
      .key_release(key_release), .key_repeat(key_repeat), .key_held(key_held),
      .press_count(press_count), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Receiver FIFO contents and event model state
   logic [7:0] q[$];
   bit         m_ext, m_brk, m_held, m_hext;
   logic [7:0] m_hcode;
   bit         e_valid, e_ext, e_rel, e_rep, e_ovf, e_clrn;
   logic [7:0] e_code, e_cnt;
   int         init_cnt;
   bit         armed = 1'b0;
   int         dut_events = 0;
   int         dut_repeats = 0;
   int         cyc = 0;
   int         last_low = -100;

   function automatic void model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         e_valid = 1'b1;
         e_code  = b;
         e_ext   = m_ext;
         if (m_brk) begin
            e_rel = 1'b1; e_rep = 1'b0;
            if (m_held && m_hcode == b && m_hext == m_ext) m_held = 1'b0;
         end else if (m_held && m_hcode == b && m_hext == m_ext) begin
            e_rel = 1'b0; e_rep = 1'b1;
         end else begin
            e_rel = 1'b0; e_rep = 1'b0;
            e_cnt = e_cnt + 8'd1;
            m_held = 1'b1; m_hcode = b; m_hext = m_ext;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      {m_ext, m_brk, m_held, m_hext} = 4'b0000;
      m_hcode = 8'h00;
      {e_valid, e_ext, e_rel, e_rep, e_ovf, e_clrn} = 6'b000000;
      e_code = 8'h00;
      e_cnt = 8'h00;
      init_cnt = 0;
      q.delete();
   endfunction

   task automatic step();
      bit r, nd, cl, ov, oc;
      r = reset; nd = kbd_nextdata_n; cl = kbd_clrn; ov = kbd_overflow; oc = ovf_clr;
      @(posedge clock);
      #1;
      if (r) begin
         model_reset();
      end else begin
         e_ovf = ov ? 1'b1 : (oc ? 1'b0 : e_ovf);
         e_valid = 1'b0;
         if (!nd) begin
            check("pop_nonempty", q.size() != 0, 1);
            if (q.size() != 0) model_byte(q.pop_front());
         end
         if (!cl) q.delete();
         if (init_cnt < CLR) init_cnt++;
         e_clrn = (init_cnt >= CLR);
      end
      armed = 1'b1;
      kbd_ready = (q.size() != 0);
      kbd_data = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   task automatic send(input logic [7:0] b);
      q.push_back(b);
      kbd_ready = 1'b1;
      kbd_data = q[0];
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && q.size() != 0; i++) step();
      check("drain_done", q.size(), 0);
      repeat (4) step();
   endtask

   task automatic apply_reset();
      int n;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && kbd_clrn == 1'b0; i++) begin
         n++;
         step();
      end
      check("clrn_low_cycles", n, CLR);
      check("reset_count", press_count, 0);
      check("reset_nd", kbd_nextdata_n, 1);
   endtask

   // Per-cycle comparison of the DUT against the model, plus handshake shape
   always @(negedge clock) begin
      if (armed) begin
         cyc++;
         check("key_valid", key_valid, e_valid);
         check("key_code", key_code, e_code);
         check("key_ext", key_ext, e_ext);
         check("key_release", key_release, e_rel);
         check("key_repeat", key_repeat, e_rep);
         check("key_held", key_held, m_held);
         check("press_count", press_count, e_cnt);
         check("ovf_sticky", ovf_sticky, e_ovf);
         check("kbd_clrn", kbd_clrn, e_clrn);
         if (key_valid === 1'b1) begin
            dut_events++;
            if (key_repeat === 1'b1) dut_repeats++;
         end
         if (kbd_nextdata_n === 1'b0) begin
            check("nd_spacing", (cyc - last_low) >= 3, 1);
            last_low = cyc;
         end
         if (kbd_clrn === 1'b0) check("nd_during_clear", kbd_nextdata_n, 1);
      end
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int ev, rp;
      logic [7:0] c;
      model_reset();

      // Press and release of 1C
      apply_reset();
      ev = dut_events;
      send(8'h1C); send(8'hF0); send(8'h1C);
      drain();
      check("s1_events", dut_events - ev, 2);
      check("s1_count", press_count, 1);
      check("s1_held", key_held, 0);
      check("s1_code", key_code, 8'h1C);
      check("s1_release", key_release, 1);

      // Typematic repeats
      apply_reset();
      ev = dut_events; rp = dut_repeats;
      send(8'h1B); send(8'h1B); send(8'h1B); send(8'hF0); send(8'h1B);
      drain();
      check("s2_events", dut_events - ev, 4);
      check("s2_repeats", dut_repeats - rp, 2);
      check("s2_count", press_count, 1);
      check("s2_held", key_held, 0);

      // Extended key with both prefix orders on release
      apply_reset();
      ev = dut_events;
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      drain();
      check("s3_events", dut_events - ev, 2);
      check("s3_code", key_code, 8'h75);
      check("s3_ext", key_ext, 1);
      check("s3_release", key_release, 1);
      check("s3_held", key_held, 0);
      send(8'hF0); send(8'hE0); send(8'h75);
      drain();
      check("s3_f0e0_ext", key_ext, 1);
      check("s3_f0e0_events", dut_events - ev, 3);

      // 256 distinct press/release pairs wrap the counter
      apply_reset();
      ev = dut_events;
      for (int k = 0; k < 256; k++) begin
         c = 8'((k % 128) + 1);
         if (k >= 128) send(8'hE0);
         send(c);
         if (k >= 128) send(8'hE0);
         send(8'hF0);
         send(c);
         drain();
      end
      check("wrap_count", press_count, 0);
      check("wrap_events", dut_events - ev, 512);
      check("wrap_held", key_held, 0);

      // Sticky overflow
      kbd_overflow = 1'b1; step(); kbd_overflow = 1'b0;
      check("ovf_set", ovf_sticky, 1);
      kbd_overflow = 1'b1; ovf_clr = 1'b1; step(); kbd_overflow = 1'b0; ovf_clr = 1'b0;
      check("ovf_set_wins", ovf_sticky, 1);
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      check("ovf_cleared", ovf_sticky, 0);

      // Random byte stream with overflow noise
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 35 && q.size() < 4) begin
            case ($urandom_range(0, 5))
               0: send(8'hE0);
               1: send(8'hF0);
               2: send(8'h1C);
               3: send(8'h1B);
               4: send(8'h75);
               default: send(8'($urandom_range(0, 255)));
            endcase
         end
         kbd_overflow = ($urandom_range(0, 99) < 4);
         ovf_clr = ($urandom_range(0, 99) < 6);
         step();
      end
      kbd_overflow = 1'b0;
      ovf_clr = 1'b0;
      drain();

      // Reset arriving mid-handshake
      apply_reset();
      send(8'h1C);
      drain();
      check("abort_pre_held", key_held, 1);
      send(8'h1B);
      for (int i = 0; i < 50 && kbd_nextdata_n !== 1'b0; i++) step();
      check("abort_reached_pop", kbd_nextdata_n, 0);
      ev = dut_events;
      reset = 1'b1;
      step();
      check("abort_nd_high", kbd_nextdata_n, 1);
      check("abort_clrn_low", kbd_clrn, 0);
      check("abort_count", press_count, 0);
      check("abort_held", key_held, 0);
      reset = 1'b0;
      repeat (10) step();
      check("abort_no_event", dut_events - ev, 0);
      check("abort_idle_count", press_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
